// File: rtl/cu_sequencer.sv
// cu_sequencer: microcode sequencer for the CPU control unit.
// Owns the micro-PC that addresses the external combinational microcode ROM
// and interprets each word's advance field (bits 31:30) to choose the next
// microstep. It also handles opcode dispatch, conditional early termination,
// bus-wait stalls and the HALT state. The ROM word is passed through to the
// field mapper, except that write enables are masked off while stalled.

module cu_sequencer #(
  parameter int UPC_W      = 10,
  parameter int FETCH_ADDR = 0
) (
  input  logic             clock,
  input  logic             reset,
  output logic [UPC_W-1:0] upc,
  input  logic [64:0]      rom_word,
  input  logic [UPC_W-1:0] entry_addr,
  input  logic             cond_true,
  input  logic             mem_wait,
  input  logic             halt_req,
  input  logic             wake,
  output logic [64:0]      control_signals,
  output logic             instr_done
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ADV_NEXT     = 2'b00,
    ADV_DISPATCH = 2'b01,
    ADV_COND     = 2'b10,
    ADV_END      = 2'b11
  } adv_t;

  localparam logic [UPC_W-1:0] FetchAddr = UPC_W'(FETCH_ADDR);

  // Idle word: everything inactive except the active-low bus strobes
  // db_nwrite (bit 4) and db_nread (bit 32), which are held deasserted.
  localparam logic [64:0] NopWord = (65'd1 << 4) | (65'd1 << 32);

  // Every write-enable field of the control word. These are cleared during a
  // bus stall so the frozen step cannot commit a write more than once.
  // Bus selects and strobes are not included, so the access stays asserted.
  localparam logic [64:0] WriteEnableMask =
      (65'd1 << 21) | (65'd1 << 28) | (65'd1 << 29) | (65'd1 << 39) |
      (65'd1 << 40) | (65'd1 << 41) | (65'd1 << 42) | (65'd1 << 52) |
      (65'd1 << 55) | (65'd1 << 56) | (65'd1 << 62) | (65'd1 << 63) |
      (65'd1 << 64);

  state_t           state_q, state_d;
  logic [UPC_W-1:0] upc_q, upc_d;
  adv_t             adv;
  logic             stepEnds;

  // The current step ends its instruction if it is an explicit end, or a
  // conditional step whose condition failed.
  assign adv      = adv_t'(rom_word[31:30]);
  assign stepEnds = (adv == ADV_END) || ((adv == ADV_COND) && !cond_true);
  assign upc      = upc_q;

  // State and micro-PC registers. Reset drops straight back to the fetch
  // routine, abandoning any instruction or stall that is in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      upc_q   <= FetchAddr;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
    end
  end

  // Next-state and next-uPC selection. A stalled RUN cycle holds everything.
  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    case (state_q)
      INIT: begin
        state_d = RUN;
        upc_d   = FetchAddr;
      end
      RUN: begin
        if (!mem_wait) begin
          case (adv)
            ADV_NEXT:     upc_d = upc_q + UPC_W'(1);
            ADV_DISPATCH: upc_d = entry_addr;
            ADV_COND:     upc_d = cond_true ? (upc_q + UPC_W'(1)) : FetchAddr;
            ADV_END:      upc_d = FetchAddr;
            default:      upc_d = upc_q;
          endcase
          if (stepEnds && halt_req) begin
            state_d = HALT;
          end
        end
      end
      HALT: begin
        upc_d = FetchAddr;
        if (wake) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = INIT;
        upc_d   = FetchAddr;
      end
    endcase
  end

  // Control word and end-of-instruction pulse. Outside RUN the NOP word is
  // driven; while stalled the write enables are masked and no pulse is given.
  always_comb begin
    control_signals = NopWord;
    instr_done      = 1'b0;
    if (state_q == RUN) begin
      if (mem_wait) begin
        control_signals = rom_word & ~WriteEnableMask;
      end else begin
        control_signals = rom_word;
        instr_done      = stepEnds;
      end
    end
  end

endmodule

// File: tb/tb_cu_sequencer.sv
// Self-checking bench for cu_sequencer.
// A behavioural ROM table feeds the DUT. Each scenario task queues per-cycle
// stimulus together with the outputs that cycle must show, then replays the
// queue. Each entry is driven #1 after the clock edge and compared #2 after it.

module tb_cu_sequencer;

  localparam logic [64:0] NOP = (65'd1 << 4) | (65'd1 << 32);
  localparam logic [64:0] WE  =
      (65'd1 << 21) | (65'd1 << 28) | (65'd1 << 29) | (65'd1 << 39) |
      (65'd1 << 40) | (65'd1 << 41) | (65'd1 << 42) | (65'd1 << 52) |
      (65'd1 << 55) | (65'd1 << 56) | (65'd1 << 62) | (65'd1 << 63) |
      (65'd1 << 64);
  localparam logic [64:0] BUS = (65'h3F << 33) | (65'd1 << 4) | (65'd1 << 32);

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  upc;
  logic [64:0] romWord;
  logic [9:0]  entryAddr = 10'h000;
  logic        condTrue = 1'b0;
  logic        memWait = 1'b0;
  logic        haltReq = 1'b0;
  logic        wake = 1'b0;
  logic [64:0] controlSignals;
  logic        instrDone;

  logic [64:0] rom [0:1023];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        mw;
    logic        ct;
    logic        hr;
    logic        wk;
    logic [9:0]  upc;
    logic [64:0] cs;
    logic        done;
  } step_t;

  step_t sb[$];

  cu_sequencer #(.UPC_W(10), .FETCH_ADDR(0)) dut (
    .clock(clock),
    .reset(reset),
    .upc(upc),
    .rom_word(romWord),
    .entry_addr(entryAddr),
    .cond_true(condTrue),
    .mem_wait(memWait),
    .halt_req(haltReq),
    .wake(wake),
    .control_signals(controlSignals),
    .instr_done(instrDone)
  );

  always #5 clock = ~clock;

  assign romWord = rom[upc];

  // Distinct payload per address (address in bits 14:5) plus the advance field.
  function automatic logic [64:0] word(input logic [9:0] a, input logic [1:0] adv);
    return (65'(a) << 5) | (65'(adv) << 30);
  endfunction

  function automatic void push(input logic rst, input logic mw, input logic ct,
                               input logic hr, input logic wk, input logic [9:0] u,
                               input logic [64:0] c, input logic d);
    step_t s;
    s.rst = rst; s.mw = mw; s.ct = ct; s.hr = hr; s.wk = wk;
    s.upc = u; s.cs = c; s.done = d;
    sb.push_back(s);
  endfunction

  task automatic test_reset();
    int n = 0;
    push(1, 0, 0, 0, 0, 10'h000, NOP, 0);
    push(1, 1, 0, 1, 1, 10'h000, NOP, 0);
    while (sb.size() > 0) begin
      step_t s;
      s = sb.pop_front();
      @(posedge clock); #1;
      reset = s.rst; memWait = s.mw; condTrue = s.ct; haltReq = s.hr; wake = s.wk;
      #1;
      checks++;
      if (upc !== s.upc || controlSignals !== s.cs || instrDone !== s.done) begin
        errors++;
        $display("[TB] FAIL reset step %0d: upc=%h cs=%h done=%b, expected upc=%h cs=%h done=%b",
                 n, upc, controlSignals, instrDone, s.upc, s.cs, s.done);
      end
      n++;
    end
  endtask

  task automatic test_dispatch();
    int n = 0;
    entryAddr = 10'h040;
    rom[10'h040] = word(10'h040, 2'b00);
    rom[10'h041] = word(10'h041, 2'b11);
    push(0, 1, 0, 0, 0, 10'h000, NOP, 0);
    push(0, 0, 0, 0, 0, 10'h000, rom[0], 0);
    push(0, 0, 0, 0, 0, 10'h040, rom[10'h040], 0);
    push(0, 0, 0, 0, 0, 10'h041, rom[10'h041], 1);
    push(0, 0, 0, 0, 0, 10'h000, rom[0], 0);
    while (sb.size() > 0) begin
      step_t s;
      s = sb.pop_front();
      @(posedge clock); #1;
      reset = s.rst; memWait = s.mw; condTrue = s.ct; haltReq = s.hr; wake = s.wk;
      #1;
      checks++;
      if (upc !== s.upc || controlSignals !== s.cs || instrDone !== s.done) begin
        errors++;
        $display("[TB] FAIL dispatch step %0d: upc=%h cs=%h done=%b, expected upc=%h cs=%h done=%b",
                 n, upc, controlSignals, instrDone, s.upc, s.cs, s.done);
      end
      n++;
    end
  endtask

  task automatic test_conditional();
    int n = 0;
    entryAddr = 10'h050;
    rom[10'h050] = word(10'h050, 2'b10);
    rom[10'h051] = word(10'h051, 2'b11);
    push(1, 0, 0, 0, 0, 10'h000, NOP, 0);
    push(0, 0, 0, 0, 0, 10'h000, NOP, 0);
    push(0, 0, 0, 0, 0, 10'h000, rom[0], 0);
    push(0, 0, 0, 0, 0, 10'h050, rom[10'h050], 1);
    push(0, 0, 0, 0, 0, 10'h000, rom[0], 0);
    push(0, 0, 1, 0, 0, 10'h050, rom[10'h050], 0);
    push(0, 0, 0, 0, 0, 10'h051, rom[10'h051], 1);
    push(0, 0, 0, 0, 0, 10'h000, rom[0], 0);
    while (sb.size() > 0) begin
      step_t s;
      s = sb.pop_front();
      @(posedge clock); #1;
      reset = s.rst; memWait = s.mw; condTrue = s.ct; haltReq = s.hr; wake = s.wk;
      #1;
      checks++;
      if (upc !== s.upc || controlSignals !== s.cs || instrDone !== s.done) begin
        errors++;
        $display("[TB] FAIL conditional step %0d: upc=%h cs=%h done=%b, expected upc=%h cs=%h done=%b",
                 n, upc, controlSignals, instrDone, s.upc, s.cs, s.done);
      end
      n++;
    end
  endtask

  task automatic test_stall();
    int n = 0;
    entryAddr = 10'h060;
    rom[10'h060] = word(10'h060, 2'b00) | (65'd1 << 40) | (65'd1 << 55) | BUS;
    rom[10'h061] = word(10'h061, 2'b11) | (65'd1 << 21) | (65'd1 << 64);
    push(1, 0, 0, 0, 0, 10'h000, NOP, 0);
    push(0, 0, 0, 0, 0, 10'h000, NOP, 0);
    push(0, 0, 0, 0, 0, 10'h000, rom[0], 0);
    for (int i = 0; i < 3; i++) push(0, 1, 0, 0, 0, 10'h060, rom[10'h060] & ~WE, 0);
    push(0, 0, 0, 0, 0, 10'h060, rom[10'h060], 0);
    push(0, 1, 0, 1, 0, 10'h061, rom[10'h061] & ~WE, 0);
    push(0, 0, 0, 0, 0, 10'h061, rom[10'h061], 1);
    push(0, 0, 0, 0, 0, 10'h000, rom[0], 0);
    while (sb.size() > 0) begin
      step_t s;
      s = sb.pop_front();
      @(posedge clock); #1;
      reset = s.rst; memWait = s.mw; condTrue = s.ct; haltReq = s.hr; wake = s.wk;
      #1;
      checks++;
      if (upc !== s.upc || controlSignals !== s.cs || instrDone !== s.done) begin
        errors++;
        $display("[TB] FAIL stall step %0d: upc=%h cs=%h done=%b, expected upc=%h cs=%h done=%b",
                 n, upc, controlSignals, instrDone, s.upc, s.cs, s.done);
      end
      n++;
    end
  endtask

  task automatic test_halt();
    int n = 0;
    entryAddr = 10'h070;
    rom[10'h070] = word(10'h070, 2'b11);
    push(1, 0, 0, 0, 0, 10'h000, NOP, 0);
    push(0, 0, 0, 0, 0, 10'h000, NOP, 0);
    push(0, 0, 0, 0, 0, 10'h000, rom[0], 0);
    push(0, 0, 0, 1, 0, 10'h070, rom[10'h070], 1);
    for (int i = 0; i < 5; i++) push(0, (i == 2), 0, 1, 0, 10'h000, NOP, 0);
    push(0, 0, 0, 0, 1, 10'h000, NOP, 0);
    push(0, 0, 0, 0, 0, 10'h000, rom[0], 0);
    push(0, 0, 0, 0, 0, 10'h070, rom[10'h070], 1);
    push(0, 0, 0, 0, 0, 10'h000, rom[0], 0);
    push(0, 0, 0, 1, 1, 10'h070, rom[10'h070], 1);
    push(0, 0, 0, 0, 1, 10'h000, NOP, 0);
    push(0, 0, 0, 0, 0, 10'h000, rom[0], 0);
    while (sb.size() > 0) begin
      step_t s;
      s = sb.pop_front();
      @(posedge clock); #1;
      reset = s.rst; memWait = s.mw; condTrue = s.ct; haltReq = s.hr; wake = s.wk;
      #1;
      checks++;
      if (upc !== s.upc || controlSignals !== s.cs || instrDone !== s.done) begin
        errors++;
        $display("[TB] FAIL halt step %0d: upc=%h cs=%h done=%b, expected upc=%h cs=%h done=%b",
                 n, upc, controlSignals, instrDone, s.upc, s.cs, s.done);
      end
      n++;
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    entryAddr = 10'h3FE;
    rom[10'h3FE] = word(10'h3FE, 2'b00);
    rom[10'h3FF] = word(10'h3FF, 2'b00);
    push(1, 0, 0, 0, 0, 10'h000, NOP, 0);
    push(0, 0, 0, 0, 0, 10'h000, NOP, 0);
    push(0, 0, 0, 0, 0, 10'h000, rom[0], 0);
    push(0, 0, 0, 0, 0, 10'h3FE, rom[10'h3FE], 0);
    push(0, 0, 0, 0, 0, 10'h3FF, rom[10'h3FF], 0);
    push(0, 0, 0, 0, 0, 10'h000, rom[0], 0);
    push(0, 0, 0, 0, 0, 10'h3FE, rom[10'h3FE], 0);
    while (sb.size() > 0) begin
      step_t s;
      s = sb.pop_front();
      @(posedge clock); #1;
      reset = s.rst; memWait = s.mw; condTrue = s.ct; haltReq = s.hr; wake = s.wk;
      #1;
      checks++;
      if (upc !== s.upc || controlSignals !== s.cs || instrDone !== s.done) begin
        errors++;
        $display("[TB] FAIL wrap step %0d: upc=%h cs=%h done=%b, expected upc=%h cs=%h done=%b",
                 n, upc, controlSignals, instrDone, s.upc, s.cs, s.done);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid_stall();
    int n = 0;
    entryAddr = 10'h123;
    rom[10'h123] = word(10'h123, 2'b11) | (65'd1 << 40) | (65'd1 << 62) | BUS;
    push(1, 0, 0, 0, 0, 10'h000, NOP, 0);
    push(0, 0, 0, 0, 0, 10'h000, NOP, 0);
    push(0, 0, 0, 0, 0, 10'h000, rom[0], 0);
    push(0, 1, 0, 0, 0, 10'h123, rom[10'h123] & ~WE, 0);
    push(0, 1, 0, 0, 0, 10'h123, rom[10'h123] & ~WE, 0);
    push(1, 1, 0, 0, 0, 10'h000, NOP, 0);
    push(0, 1, 0, 0, 0, 10'h000, NOP, 0);
    push(0, 0, 0, 0, 0, 10'h000, rom[0], 0);
    while (sb.size() > 0) begin
      step_t s;
      s = sb.pop_front();
      @(posedge clock); #1;
      reset = s.rst; memWait = s.mw; condTrue = s.ct; haltReq = s.hr; wake = s.wk;
      #1;
      checks++;
      if (upc !== s.upc || controlSignals !== s.cs || instrDone !== s.done) begin
        errors++;
        $display("[TB] FAIL reset_mid_stall step %0d: upc=%h cs=%h done=%b, expected upc=%h cs=%h done=%b",
                 n, upc, controlSignals, instrDone, s.upc, s.cs, s.done);
      end
      n++;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = word(10'(i), 2'b00);
    rom[0] = word(10'h000, 2'b01);
    #1 reset = 1'b1;
    test_reset();
    test_dispatch();
    test_conditional();
    test_stall();
    test_halt();
    test_wrap();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
